// File: rtl/stage2_instr_fetch.sv
// IF stage: takes a PC from stage 1, runs a req/ack read on instruction memory
// and presents the returned word in the IF/ID register with stall/flush support.
module stage2_instr_fetch #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] inPC,
    input  logic              inPCValid,
    output logic              outPCReady,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memReq,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memData,
    input  logic              conStall,
    input  logic              conFlush,
    output logic [DATA_W-1:0] outInstr,
    output logic [ADDR_W-1:0] outPC,
    output logic              outValid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]   buf_pc_q, buf_pc_d;
    logic [DATA_W-1:0]   out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
    logic                out_valid_q, out_valid_d;

    // A fetched pair headed for IF/ID this edge, from memory or from the buffer.
    logic                load_pair;
    logic [DATA_W-1:0]   pair_instr;
    logic [ADDR_W-1:0]   pair_pc;

    assign outPCReady = (state_q == S_IDLE) && !conFlush && !Reset;
    assign memReq     = mem_req_q;
    assign memAddr    = mem_addr_q;
    assign outInstr   = out_instr_q;
    assign outPC      = out_pc_q;
    assign outValid   = out_valid_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        load_pair   = 1'b0;
        pair_instr  = memData;
        pair_pc     = mem_addr_q;

        case (state_q)
            S_IDLE: begin
                if (inPCValid && outPCReady) begin
                    mem_addr_d = inPC;
                    mem_req_d  = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    if (conFlush) begin
                        state_d = S_IDLE;
                    end else if (!conStall) begin
                        load_pair = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        buf_instr_d = memData;
                        buf_pc_d    = mem_addr_q;
                        state_d     = S_FULL;
                    end
                end else if (conFlush) begin
                    // The read cannot be aborted; let it finish and throw it away.
                    state_d = S_DRAIN;
                end
            end
            S_FULL: begin
                pair_instr = buf_instr_q;
                pair_pc    = buf_pc_q;
                if (conFlush) begin
                    state_d = S_IDLE;
                end else if (!conStall) begin
                    load_pair = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // IF/ID register: flush beats stall; an idle unstalled edge inserts a bubble.
    always_comb begin
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        if (conFlush) begin
            out_instr_d = NOP_INSTR;
            out_valid_d = 1'b0;
        end else if (load_pair) begin
            out_instr_d = pair_instr;
            out_pc_d    = pair_pc;
            out_valid_d = 1'b1;
        end else if (!conStall) begin
            out_instr_d = NOP_INSTR;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
